// File: rtl/minority_bist_pkg.sv
// rtl/minority_bist_pkg.sv - shared types, constants and golden model for minority_bist
// Contents:
//   state_t       - controller state encoding (IDLE, SETTLE, SAMPLE, DONE)
//   NUM_VECTORS   - number of exhaustive input vectors for a 3-input gate
//   minority_ref  - golden minority function, also used by the bench
package minority_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 8;

    function automatic logic minority_ref(input logic a, input logic b, input logic c);
        return ~((a & b) | (a & c) | (b & c));
    endfunction

endpackage

// File: rtl/minority_bist.sv
// rtl/minority_bist.sv - exhaustive self-test controller for a 3-input minority gate
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before y is sampled (>= 1)
//   COUNT_W        width of the saturating fail_count
// Ports:
//   clk, reset_n   clock (rising edge) and asynchronous active-low reset
//   start          run request, level-sampled in IDLE only
//   abort          (MINORITY_BIST_ABORT_EN only) ends a run early with pass=0
//   busy           high while vectors are being applied (SETTLE/SAMPLE)
//   done           one-cycle pulse in the DONE state
//   pass           result of the last run, held until the next run starts
//   fail_count     mismatching vectors in the last/current run, saturating
//   first_fail_vec {a,b,c} of the first mismatch of the run
//   a, b, c        registered drive to the gate under test
//   y              gate output, sampled synchronously in SAMPLE
// Build option: define MINORITY_BIST_ABORT_EN to add the abort input.
module minority_bist
    import minority_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int COUNT_W       = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
`ifdef MINORITY_BIST_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [COUNT_W-1:0] fail_count,
    output logic [2:0]         first_fail_vec,
    output logic               a,
    output logic               b,
    output logic               c,
    input  logic               y
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
    localparam logic [2:0]         LAST_VEC  = 3'(NUM_VECTORS - 1);

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic [2:0]       vec;
    logic             abort_req;
    logic             mismatch;

`ifdef MINORITY_BIST_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // The drive register is the vector counter itself, so a/b/c only change
    // on the edge that starts a vector's first SETTLE cycle.
    assign {a, b, c} = vec;
    assign mismatch  = (y != minority_ref(vec[2], vec[1], vec[0]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            settle_cnt     <= '0;
            vec            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_vec <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec            <= '0;
                        fail_count     <= '0;
                        pass           <= 1'b0;
                        first_fail_vec <= '0;
                        settle_cnt     <= CNT_LOAD;
                        busy           <= 1'b1;
                        state          <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (abort_req) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                        state <= ST_DONE;
                    end else if (settle_cnt == '0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (abort_req) begin
                        // The comparison of this cycle is discarded.
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        if (mismatch) begin
                            if (fail_count != COUNT_MAX) begin
                                fail_count <= fail_count + 1'b1;
                            end
                            // A zero count means no earlier mismatch in this run;
                            // saturation never wraps it back to zero.
                            if (fail_count == '0) begin
                                first_fail_vec <= vec;
                            end
                        end
                        if (vec == LAST_VEC) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fail_count == '0) && !mismatch;
                            state <= ST_DONE;
                        end else begin
                            vec        <= vec + 1'b1;
                            settle_cnt <= CNT_LOAD;
                            state      <= ST_SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minority_bist.sv
// tb/tb_minority_bist.sv - self-checking bench for minority_bist
module tb_minority_bist;
    import minority_bist_pkg::*;

    typedef struct packed {
        logic       pass;
        logic [3:0] cnt;
        logic [2:0] ffv;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       start;
`ifdef MINORITY_BIST_ABORT_EN
    logic       abort;
`endif
    logic       busy, done, pass, a, b, c, y;
    logic [3:0] fail_count;
    logic [2:0] first_fail_vec;
    logic       busy2, done2, pass2, a2, b2, c2, y2;
    logic [1:0] fail_count2;
    logic [2:0] first_fail_vec2;

    int   ymode;
    int   n_vec;
    int   n_miss;
    exp_t sb1[$];
    exp_t sb2[$];

    minority_bist #(.SETTLE_CYCLES(2), .COUNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
`ifdef MINORITY_BIST_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail_vec(first_fail_vec), .a(a), .b(b), .c(c), .y(y)
    );

    // Second instance: narrow counter, always wired to a majority gate.
    minority_bist #(.SETTLE_CYCLES(2), .COUNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start),
`ifdef MINORITY_BIST_ABORT_EN
        .abort(abort),
`endif
        .busy(busy2), .done(done2), .pass(pass2), .fail_count(fail_count2),
        .first_fail_vec(first_fail_vec2), .a(a2), .b(b2), .c(c2), .y(y2)
    );

    // Gate under test models: 0 good minority, 1 stuck-at-0, 2 majority.
    always_comb begin
        y = 1'b0;
        case (ymode)
            0:       y = minority_ref(a, b, c);
            2:       y = ~minority_ref(a, b, c);
            default: y = 1'b0;
        endcase
    end
    assign y2 = ~minority_ref(a2, b2, c2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result of one run: vectors whose sample cycle is at or after
    // the abort cycle are never judged.
    function automatic exp_t model(input int mode, input int abort_cyc, input int cw);
        exp_t r;
        int   cnt;
        bit   seen;
        logic yy;
        logic [2:0] v3;
        r = '0;
        cnt = 0;
        seen = 0;
        for (int v = 0; v < NUM_VECTORS; v++) begin
            if (abort_cyc != 0 && (v + 1) * 3 >= abort_cyc) break;
            v3 = 3'(v);
            yy = (mode == 0) ? minority_ref(v3[2], v3[1], v3[0]) :
                 (mode == 2) ? ~minority_ref(v3[2], v3[1], v3[0]) : 1'b0;
            if (yy !== minority_ref(v3[2], v3[1], v3[0])) begin
                if (!seen) r.ffv = v3;
                seen = 1;
                if (cnt < (1 << cw) - 1) cnt++;
            end
        end
        r.cnt  = 4'(cnt);
        r.pass = !seen && (abort_cyc == 0);
        return r;
    endfunction

    task automatic run(input string tag, input int mode, input int runs, input int abort_cyc);
        int   cyc;
        int   got;
        int   done_cyc;
        exp_t e;
        ymode = mode;
        done_cyc = (abort_cyc != 0) ? abort_cyc + 1 : 8 * 3 + 1;
        for (int r = 0; r < runs; r++) begin
            sb1.push_back(model(mode, abort_cyc, 4));
            sb2.push_back(model(2, abort_cyc, 2));
        end
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        got = 0;
        while (got < runs && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (runs == 1) begin
                chk({tag, "_busy"}, 32'(busy), 32'(cyc < done_cyc));
                if (abort_cyc == 0 && cyc % 3 == 0 && cyc <= 24)
                    chk({tag, "_abc"}, 32'({a, b, c}), 32'(cyc / 3 - 1));
            end
            if (done) begin
                got++;
                chk({tag, "_done_cycle"}, 32'(cyc), 32'(done_cyc + 26 * (got - 1)));
                chk({tag, "_busy_in_done"}, 32'(busy), 32'(0));
                e = sb1.pop_front();
                chk({tag, "_pass"}, 32'(pass), 32'(e.pass));
                chk({tag, "_fail_count"}, 32'(fail_count), 32'(e.cnt));
                if (!e.pass) chk({tag, "_first_fail"}, 32'(first_fail_vec), 32'(e.ffv));
                e = sb2.pop_front();
                chk({tag, "_w2_done"}, 32'(done2), 32'(1));
                chk({tag, "_w2_pass"}, 32'(pass2), 32'(e.pass));
                chk({tag, "_w2_fail_count"}, 32'(fail_count2), 32'(e.cnt));
                chk({tag, "_w2_first_fail"}, 32'(first_fail_vec2), 32'(e.ffv));
            end
            if (cyc == 1 && runs == 1) start = 1'b0;
`ifdef MINORITY_BIST_ABORT_EN
            abort = (abort_cyc != 0 && cyc == abort_cyc);
`endif
        end
        chk({tag, "_done_seen"}, 32'(got), 32'(runs));
        start = 1'b0;
`ifdef MINORITY_BIST_ABORT_EN
        abort = 1'b0;
`endif
        @(negedge clk);
        chk({tag, "_idle_done"}, 32'(done), 32'(0));
        chk({tag, "_idle_busy"}, 32'(busy), 32'(0));
        sb1.delete();
        sb2.delete();
    endtask

    initial begin
        int dones;
        n_vec = 0;
        n_miss = 0;
        ymode = 0;
        start = 1'b0;
`ifdef MINORITY_BIST_ABORT_EN
        abort = 1'b0;
`endif
        reset_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_pass", 32'(pass), 32'(0));
        chk("rst_fail_count", 32'(fail_count), 32'(0));
        chk("rst_first_fail", 32'(first_fail_vec), 32'(0));
        chk("rst_abc", 32'({a, b, c}), 32'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        run("good", 0, 1, 0);
        run("stuck0", 1, 1, 0);
        run("majority", 2, 1, 0);
        run("held_start", 1, 2, 0);

        // Reset in the middle of a run.
        ymode = 1;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mid_fail_count", 32'(fail_count), 32'(3));
        chk("mid_busy", 32'(busy), 32'(1));
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_done", 32'(done), 32'(0));
        chk("arst_fail_count", 32'(fail_count), 32'(0));
        chk("arst_first_fail", 32'(first_fail_vec), 32'(0));
        chk("arst_abc", 32'({a, b, c}), 32'(0));
        chk("arst_w2_busy", 32'(busy2), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("arst_no_done", 32'(dones), 32'(0));
        run("after_reset", 0, 1, 0);

`ifdef MINORITY_BIST_ABORT_EN
        run("abort", 1, 1, 5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
